// File: rtl/emm_ddr_32to8.sv
// -----------------------------------------------------------------------------
// emm_ddr_32to8
//
// Word-to-byte serializer for the DDR read path. 33-bit words (bit 32 = SOP,
// bits 31:0 = data, first byte in [31:24]) are buffered in a small FIFO and
// shifted out one byte per cycle as a 9-bit stream (bit 8 = SOP, bits 7:0 =
// data). The output has no backpressure.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   din_en      word valid, accepted only while din_rdy=1
//   din         [32]=SOP, [31:0]=data, big-endian byte order
//   din_last    word is the last of a packet
//   din_nbytes  valid bytes in a last word (0 means 4)
//   din_rdy     FIFO not full
//   dout_en     byte valid
//   dout        [8]=SOP, [7:0]=byte; 0 whenever dout_en=0
//   pkt_cnt     packets fully emitted, wraps
//   ovf_err     sticky: din_en seen while din_rdy=0
//
// Parameters:
//   FIFO_DEPTH  input word FIFO entries (power of 2, >= 2)
//   GAP_CYCLES  idle cycles after each packet end (>= 1, PKT_GAP_EN only)
//
// Build option:
//   PKT_GAP_EN  when defined, GAP_CYCLES idle cycles follow the final byte of
//               every packet, even if more words are waiting.
// -----------------------------------------------------------------------------
module emm_ddr_32to8 #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_en,
    input  logic [32:0] din,
    input  logic        din_last,
    input  logic [1:0]  din_nbytes,
    output logic        din_rdy,
    output logic        dout_en,
    output logic [8:0]  dout,
    output logic [15:0] pkt_cnt,
    output logic        ovf_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef PKT_GAP_EN
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PKT_GAP_EN
        , GAP
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO: entry = {last, nbytes[1:0], sop, data[31:0]}
    // ------------------------------------------------------------------
    logic [35:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [35:0]   head;

    // Full is judged on the registered count alone, so a pop in the same
    // cycle never lets a push through a full FIFO.
    assign din_rdy    = (count != FULL_CNT);
    assign fifo_empty = (count == '0);
    assign push       = din_en & din_rdy;
    assign head       = mem[rd_ptr];

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {din_last, din_nbytes, din};
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (din_en && !din_rdy) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM and shift register
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_nxt;
    logic [31:0] sreg;
    logic [31:0] sreg_nxt;
    logic [1:0]  idx;
    logic [1:0]  idx_nxt;
    logic        sop_r;
    logic        sop_nxt;
    logic        last_r;
    logic        last_nxt;
    logic [1:0]  nbytes_r;
    logic [1:0]  nbytes_nxt;
    logic        dout_en_nxt;
    logic [8:0]  dout_nxt;
    logic [15:0] pkt_cnt_nxt;
    logic [1:0]  final_idx;

`ifdef PKT_GAP_EN
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_nxt;
`endif

    // Index of the last byte to emit from the current word.
    assign final_idx = (last_r && (nbytes_r != 2'd0)) ? (nbytes_r - 2'd1) : 2'd3;

    // All registers, including the output byte, advance together here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sreg     <= '0;
            idx      <= '0;
            sop_r    <= 1'b0;
            last_r   <= 1'b0;
            nbytes_r <= '0;
            dout_en  <= 1'b0;
            dout     <= '0;
            pkt_cnt  <= '0;
`ifdef PKT_GAP_EN
            gap_cnt  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            idx      <= idx_nxt;
            sop_r    <= sop_nxt;
            last_r   <= last_nxt;
            nbytes_r <= nbytes_nxt;
            dout_en  <= dout_en_nxt;
            dout     <= dout_nxt;
            pkt_cnt  <= pkt_cnt_nxt;
`ifdef PKT_GAP_EN
            gap_cnt  <= gap_cnt_nxt;
`endif
        end
    end

    // Next-state and datapath decode. Loading a new word always happens
    // together with a pop, so the head entry is copied into the shift
    // register and its framing fields are latched in one place per branch.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        sreg_nxt    = sreg;
        idx_nxt     = idx;
        sop_nxt     = sop_r;
        last_nxt    = last_r;
        nbytes_nxt  = nbytes_r;
        dout_en_nxt = 1'b0;
        dout_nxt    = '0;
        pkt_cnt_nxt = pkt_cnt;
`ifdef PKT_GAP_EN
        gap_cnt_nxt = gap_cnt;
`endif

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    sreg_nxt   = head[31:0];
                    sop_nxt    = head[32];
                    nbytes_nxt = head[34:33];
                    last_nxt   = head[35];
                    idx_nxt    = '0;
                    state_nxt  = SHIFT;
                end
            end

            SHIFT: begin
                dout_en_nxt = 1'b1;
                dout_nxt    = {sop_r & (idx == 2'd0), sreg[31:24]};
                sreg_nxt    = {sreg[23:0], 8'h00};
                idx_nxt     = idx + 2'd1;
                if (idx == final_idx) begin
                    if (last_r) begin
                        pkt_cnt_nxt = pkt_cnt + 16'd1;
                    end
`ifdef PKT_GAP_EN
                    if (last_r) begin
                        gap_cnt_nxt = '0;
                        state_nxt   = GAP;
                    end else
`endif
                    if (!fifo_empty) begin
                        // Back-to-back load: the next word's first byte
                        // follows this final byte with no bubble.
                        pop        = 1'b1;
                        sreg_nxt   = head[31:0];
                        sop_nxt    = head[32];
                        nbytes_nxt = head[34:33];
                        last_nxt   = head[35];
                        idx_nxt    = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

`ifdef PKT_GAP_EN
            GAP: begin
                gap_cnt_nxt = gap_cnt + GW'(1);
                if (gap_cnt == GAP_LAST) begin
                    // Loading on the last gap cycle keeps the idle run at
                    // exactly GAP_CYCLES instead of adding an IDLE cycle.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        sreg_nxt   = head[31:0];
                        sop_nxt    = head[32];
                        nbytes_nxt = head[34:33];
                        last_nxt   = head[35];
                        idx_nxt    = '0;
                        state_nxt  = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
`endif

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_emm_ddr_32to8.sv
// -----------------------------------------------------------------------------
// tb_emm_ddr_32to8
//
// Self-checking bench for emm_ddr_32to8. Every accepted word is expanded into
// its expected bytes in a scoreboard queue; a negedge monitor pops and
// compares each emitted byte, its spacing and the packet counter.
// -----------------------------------------------------------------------------
module tb_emm_ddr_32to8;

    localparam int GAP_CYC = 2;
`ifdef PKT_GAP_EN
    localparam int PKT_GAP_EXP = GAP_CYC;
`else
    localparam int PKT_GAP_EXP = 0;
`endif

    logic        clk;
    logic        rst;
    logic        din_en;
    logic [32:0] din;
    logic        din_last;
    logic [1:0]  din_nbytes;
    logic        din_rdy;
    logic        dout_en;
    logic [8:0]  dout;
    logic [15:0] pkt_cnt;
    logic        ovf_err;

    emm_ddr_32to8 #(
        .FIFO_DEPTH (4),
        .GAP_CYCLES (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_en     (din_en),
        .din        (din),
        .din_last   (din_last),
        .din_nbytes (din_nbytes),
        .din_rdy    (din_rdy),
        .dout_en    (dout_en),
        .dout       (dout),
        .pkt_cnt    (pkt_cnt),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected byte with its framing and timing requirements.
    // gap: idle cycles required before this byte (-1 = don't care)
    // due: absolute cycle it must appear in (-1 = don't care)
    typedef struct {
        logic [8:0] val;
        logic       pktEnd;
        int         gap;
        int         due;
    } exp_t;

    exp_t        expQ[$];
    int          nVectors    = 0;
    int          nMiscompares = 0;
    int          cyc         = 0;
    int          lastCyc     = 0;
    logic [15:0] expPkt      = '0;
    logic        expOvf      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // The one comparison point of the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     tag, cyc, actual, expected);
        end
    endtask

    // Expand one word into bytes following the framing rules.
    task automatic pushExpected(input logic [32:0] w, input logic last,
                                input logic [1:0] nb, input int firstGap,
                                input int due);
        int   n;
        exp_t e;
        n = (last && nb != 2'd0) ? int'(nb) : 4;
        for (int i = 0; i < n; i++) begin
            e.val    = {(w[32] && i == 0), 8'(w[31:0] >> (24 - 8 * i))};
            e.pktEnd = last && (i == n - 1);
            e.gap    = (i == 0) ? firstGap : 0;
            e.due    = (i == 0) ? due : -1;
            expQ.push_back(e);
        end
    endtask

    // One cycle of input drive, called just after a rising edge.
    task automatic applyStimulus(input logic en, input logic [32:0] w,
                                 input logic last, input logic [1:0] nb,
                                 input int firstGap, input logic trackDue,
                                 output logic accepted);
        din_en     = en;
        din        = w;
        din_last   = last;
        din_nbytes = nb;
        #1;
        accepted = en && din_rdy;
        if (accepted) begin
            pushExpected(w, last, nb, firstGap, trackDue ? cyc + 3 : -1);
        end
        if (en && !din_rdy) begin
            expOvf = 1'b1;
        end
        @(posedge clk);
        #1;
        din_en = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Push a word, waiting (bounded) for din_rdy first.
    task automatic sendWord(input logic [32:0] w, input logic last,
                            input logic [1:0] nb, input int firstGap);
        logic acc;
        int   tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 50) begin
            if (din_rdy) begin
                applyStimulus(1'b1, w, last, nb, firstGap, 1'b0, acc);
            end else begin
                idleCycles(1);
            end
            tries++;
        end
        if (!acc) checkOutput("rdy_timeout", {31'd0, din_rdy}, 1);
    endtask

    // Wait until every expected byte has been seen, then let the FSM settle.
    task automatic drain();
        int budget;
        budget = 400;
        while (expQ.size() != 0 && budget > 0) begin
            idleCycles(1);
            budget--;
        end
        checkOutput("drain", expQ.size(), 0);
        idleCycles(6);
    endtask

    // Output monitor / scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (dout_en) begin
            if (expQ.size() == 0) begin
                checkOutput("extra_byte", {31'd0, dout_en}, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("byte", {23'd0, dout}, {23'd0, e.val});
                if (e.gap >= 0) checkOutput("gap", cyc - lastCyc - 1, e.gap);
                if (e.due >= 0) checkOutput("latency", cyc, e.due);
                if (e.pktEnd) begin
                    expPkt = expPkt + 16'd1;
                    checkOutput("pkt_cnt", {16'd0, pkt_cnt}, {16'd0, expPkt});
                end
            end
            lastCyc = cyc;
        end else begin
            checkOutput("idle_dout", {23'd0, dout}, 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        acc;
        logic [32:0] w;
        logic        rdyExp [10];
        logic        sopNext;
        logic        lst;
        logic [1:0]  nb;

        din_en = 1'b0; din = '0; din_last = 1'b0; din_nbytes = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_dout_en", {31'd0, dout_en}, 0);
        checkOutput("rst_dout", {23'd0, dout}, 0);
        checkOutput("rst_pkt_cnt", {16'd0, pkt_cnt}, 0);
        checkOutput("rst_ovf", {31'd0, ovf_err}, 0);
        checkOutput("rst_rdy", {31'd0, din_rdy}, 1);
        rst = 1'b1;
        idleCycles(2);

        // 1: single full word, latency 2 edges after acceptance
        applyStimulus(1'b1, 33'h1_0200_0001, 1'b1, 2'd0, -1, 1'b1, acc);
        drain();
        checkOutput("t1_pkt_cnt", {16'd0, pkt_cnt}, 1);

        // 2: partial tail, 6 contiguous bytes
        sendWord(33'h1_C012_0802, 1'b0, 2'd0, -1);
        sendWord(33'h0_4E20_0000, 1'b1, 2'd2, 0);
        drain();
        checkOutput("t2_pkt_cnt", {16'd0, pkt_cnt}, 2);

        // 3: 46-word packet with bytes 1..184, honouring din_rdy
        for (int j = 0; j < 46; j++) begin
            w = {(j == 0), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3), 8'(4*j+4)};
            sendWord(w, (j == 45), 2'd0, (j == 0) ? -1 : 0);
        end
        drain();
        checkOutput("t3_ovf", {31'd0, ovf_err}, 0);

        // 6: two one-word packets back-to-back
        sendWord(33'h1_AABB_CCDD, 1'b1, 2'd0, -1);
        sendWord(33'h1_1122_3344, 1'b1, 2'd0, PKT_GAP_EXP);
        drain();

        // 4: ten cycles of din_en ignoring din_rdy into a depth-4 FIFO
        rdyExp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
`ifndef PKT_GAP_EN
            checkOutput("t4_rdy", {31'd0, din_rdy}, {31'd0, rdyExp[i]});
`endif
            w = {1'b1, 8'(i), 8'hA5, 8'h5A, 8'(i + 16)};
            applyStimulus(1'b1, w, 1'b1, 2'd0, -1, 1'b0, acc);
        end
        checkOutput("t4_ovf", {31'd0, ovf_err}, {31'd0, expOvf});
        drain();
        checkOutput("t4_ovf_sticky", {31'd0, ovf_err}, 1);

        // Randomized traffic against the scoreboard
        sopNext = 1'b1;
        for (int k = 0; k < 80; k++) begin
            lst = ($urandom_range(0, 2) == 0);
            nb  = 2'($urandom_range(0, 3));
            w   = {sopNext, 32'($urandom)};
            if ($urandom_range(0, 3) == 0) begin
                idleCycles($urandom_range(1, 6));
            end
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus(1'b1, w, lst, nb, -1, 1'b0, acc);
            end else begin
                sendWord(w, lst, nb, -1);
                acc = 1'b1;
            end
            if (acc) sopNext = lst;
        end
        drain();
        checkOutput("rnd_ovf", {31'd0, ovf_err}, {31'd0, expOvf});
        checkOutput("rnd_pkt_cnt", {16'd0, pkt_cnt}, {16'd0, expPkt});

        // 5: reset during the second byte of a word
        applyStimulus(1'b1, 33'h0_DEAD_BEEF, 1'b0, 2'd0, -1, 1'b1, acc);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_pre_en", {31'd0, dout_en}, 1);
        checkOutput("t5_pre_byte", {23'd0, dout}, 9'h0AD);
        rst = 1'b0;
        expQ.delete();
        expPkt = '0;
        expOvf = 1'b0;
        #1;
        checkOutput("t5_dout_en", {31'd0, dout_en}, 0);
        checkOutput("t5_dout", {23'd0, dout}, 0);
        idleCycles(2);
        rst = 1'b1;
        #1;
        checkOutput("t5_rdy", {31'd0, din_rdy}, 1);
        checkOutput("t5_pkt_cnt", {16'd0, pkt_cnt}, 0);
        checkOutput("t5_ovf", {31'd0, ovf_err}, 0);
        idleCycles(12);
        checkOutput("t5_residue", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/emm_ddr_32to8.md
Name: emm_ddr_32to8

Overview:
- Word-to-byte serializer: the reverse of the 8-to-32 packer on the DDR path.
- Accepts 33-bit words from the DDR read side: bit 32 is the start-of-packet flag, bits 31:0 are data, first byte in [31:24].
- Emits the 9-bit byte stream (bit 8 = SOP, bits 7:0 = data) consumed by the EMM/TS output logic.
- A small input FIFO absorbs word bursts. Output rate is 1 byte/cycle; no output backpressure.

Parameters:
FIFO_DEPTH, 4, input word FIFO entries (power of 2, >=2)
GAP_CYCLES, 2, idle cycles inserted after each packet end (PKT_GAP_EN only)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
din_en  input  1  word valid; accepted only when din_rdy=1
din  input  33  [32]=SOP, [31:0]=data, big-endian byte order
din_last  input  1  word is the last of a packet
din_nbytes  input  2  valid bytes in a last word; 0 means 4; ignored when din_last=0
din_rdy  output  1  FIFO not full
dout_en  output  1  byte valid
dout  output  9  [8]=SOP, [7:0]=byte
pkt_cnt  output  16  packets fully emitted, wraps at 65535->0
ovf_err  output  1  sticky: din_en seen while din_rdy=0

Behaviour:
- Reset (rst=0, async): dout_en=0, dout=0, pkt_cnt=0, ovf_err=0, FIFO empty, din_rdy=1, FSM=IDLE, shift register cleared.
- A partially sent word or packet is discarded; nothing resumes after reset.
- FIFO:
  - Each entry holds {din_last, din_nbytes, din}.
  - Push on din_en & din_rdy.
  - din_rdy = (count != FIFO_DEPTH), combinational from the registered count.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Refused din_en sets ovf_err and drops the word.
  - Simultaneous push and pop when not full leaves count unchanged.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: if FIFO is non-empty, pop into the shift register, set idx=0 and latch sop/last/nbytes, then go to SHIFT.
  - SHIFT: each cycle register dout_en=1 and dout={sop & (idx==0), sreg[31:24]}, then shift sreg left by 8 and increment idx.
  - Final index is 3, or (nbytes==0 ? 3 : nbytes-1) when last.
  - At the final index with last=1, pkt_cnt increments.
  - At the final index, if FIFO is non-empty (and no gap is due), pop the next word in the same cycle and stay in SHIFT. This gives no bubble between words or packets.
  - Otherwise go to IDLE, or to GAP when the gap feature applies.
  - GAP: count GAP_CYCLES cycles with dout_en=0, then go to IDLE.
- dout_en=0 cycles drive dout=0.
- Latency: word accepted at edge N into an empty FIFO in IDLE gives the first byte with dout_en=1 after edge N+2. Sustained throughput is 4 bytes per word.
- The SOP bit is taken from din[32] of each word and appears on that word's first byte only; the block does not check packet framing.

Optional Feature:
PKT_GAP_EN:
- Defined: after the final byte of a din_last word, the FSM enters GAP for GAP_CYCLES cycles before the next pop, even if the FIFO is non-empty.
- Undefined: the GAP state and counter are not built, and packets stream back-to-back.

Test Plan:
1. Single word din=33'h1_0200_0001, din_last=1, nbytes=0 into an idle block -> dout 9'h102, 9'h000, 9'h000, 9'h001 on 4 consecutive cycles. First byte appears 2 cycles after acceptance; pkt_cnt=1.
2. Partial tail: 33'h1_C012_0802 (last=0), then 33'h0_4E20_0000 (last=1, nbytes=2) -> 6 contiguous bytes 9'h1C0, 012, 008, 002, 04E, 020, then dout_en=0; pkt_cnt +1.
3. Honouring din_rdy, stream 46 words carrying bytes 1..184 (first word SOP, last word last=1) -> 184 contiguous bytes 1..184, SOP on byte 1 only, ovf_err=0.
4. FIFO_DEPTH=4: drive din_en for 10 consecutive cycles ignoring din_rdy -> din_rdy falls when full, ovf_err=1 and stays set. Output byte count = 4 × accepted words.
5. Reset low during the 2nd byte of a word -> dout_en=0 and dout=0 immediately. After release: din_rdy=1, pkt_cnt=0, and no residual bytes are emitted.
6. Two one-word packets pushed back-to-back:
   - With PKT_GAP_EN: exactly GAP_CYCLES (2) idle cycles between byte 4 and the next SOP byte.
   - Without PKT_GAP_EN: 8 contiguous bytes.
